// File: rtl/pattern_pkg.sv
// Shared definitions for the grayscale ramp generator / checker pair.
package pattern_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FRAME = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int FRAME_W_DEF = 240;
  localparam int FRAME_H_DEF = 180;
  localparam int PIXEL_W_DEF = 10;

endpackage

// File: rtl/ramp_pixel_compare.sv
// Per-line ramp reference and registered pixel mismatch flag.
module ramp_pixel_compare #(
  parameter int PIXEL_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               line_act,
  input  logic               chk_en,
  input  logic [PIXEL_W-1:0] pixel,
  output logic               mismatch
);

  logic [PIXEL_W-1:0] exp_pix;

  // The reference restarts at 0 on every line and wraps at 2^PIXEL_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_pix  <= '0;
      mismatch <= 1'b0;
    end else begin
      exp_pix  <= line_act ? exp_pix + 1'b1 : '0;
      mismatch <= chk_en && (pixel != exp_pix);
    end
  end

endmodule

// File: rtl/pattern_stream_checker.sv
// Loopback checker for the parallel pixel stream: frame geometry, aborts, stray
// line_valid and (with PATTERN_CHECK_EN) per-pixel ramp errors.
module pattern_stream_checker
  import pattern_pkg::*;
#(
  parameter int EXP_WIDTH  = FRAME_W_DEF,
  parameter int EXP_HEIGHT = FRAME_H_DEF,
  parameter int PIXEL_W    = PIXEL_W_DEF,
  parameter int CNT_W      = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               line_valid,
  input  logic               frame_valid,
  output logic               frame_done,
  output logic [CNT_W-1:0]   meas_width,
  output logic [CNT_W-1:0]   meas_height,
  output logic               geom_ok,
  output logic               frame_aborted,
  output logic               stray_lv,
  output logic [15:0]        pix_err_cnt,
  output logic [15:0]        frame_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_W_C = CNT_W'(EXP_WIDTH);
  localparam logic [CNT_W-1:0] EXP_H_C = CNT_W'(EXP_HEIGHT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_e           state;
  logic             fv_q, lv_q, lv_d;
  logic [CNT_W-1:0] x, y, pend_w;
  logic             line_bad, first_line, aborted;
  logic             line_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fv_q <= 1'b0;
      lv_q <= 1'b0;
      lv_d <= 1'b0;
    end else begin
      fv_q <= frame_valid;
      lv_q <= line_valid;
      lv_d <= lv_q;
    end
  end

  // A frame_valid drop with the line still open closes the partial line too.
  assign line_end = (lv_d && !lv_q) || (!fv_q && lv_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_SYNC;
      x             <= '0;
      y             <= '0;
      pend_w        <= '0;
      line_bad      <= 1'b0;
      first_line    <= 1'b0;
      aborted       <= 1'b0;
      frame_done    <= 1'b0;
      meas_width    <= '0;
      meas_height   <= '0;
      geom_ok       <= 1'b0;
      frame_aborted <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        // raw input so a frame still open at reset release is skipped
        ST_SYNC: if (!frame_valid) state <= ST_IDLE;
        ST_IDLE: begin
          x          <= (fv_q && lv_q) ? CNT_W'(1) : '0;
          y          <= '0;
          pend_w     <= '0;
          line_bad   <= 1'b0;
          first_line <= 1'b1;
          aborted    <= 1'b0;
          if (fv_q) state <= ST_FRAME;
        end
        ST_FRAME: begin
          if (fv_q && lv_q) x <= sat_inc(x);
          if (line_end) begin
            if (first_line) pend_w <= x;
            if (x != EXP_W_C) line_bad <= 1'b1;
            first_line <= 1'b0;
            y          <= sat_inc(y);
            x          <= '0;
          end
          if (!fv_q) begin
            aborted <= lv_q || lv_d;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          frame_done    <= 1'b1;
          meas_width    <= pend_w;
          meas_height   <= y;
          geom_ok       <= !line_bad && (y == EXP_H_C) && !aborted;
          frame_aborted <= aborted;
          frame_cnt     <= frame_cnt + 16'd1;
          state         <= ST_IDLE;
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stray_lv <= 1'b0;
    else if (state != ST_SYNC && lv_q && !fv_q) stray_lv <= 1'b1;
  end

`ifdef PATTERN_CHECK_EN
  logic [PIXEL_W-1:0] pix_q;
  logic               chk_en, pix_mismatch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pix_q <= '0;
    else       pix_q <= pixel_in;
  end

  assign chk_en = (state == ST_IDLE || state == ST_FRAME) && fv_q && lv_q;

  ramp_pixel_compare #(.PIXEL_W(PIXEL_W)) u_cmp (
    .clk      (clk),
    .reset    (reset),
    .line_act (lv_q),
    .chk_en   (chk_en),
    .pixel    (pix_q),
    .mismatch (pix_mismatch)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pix_err_cnt <= '0;
    else if (pix_mismatch && pix_err_cnt != 16'hFFFF) pix_err_cnt <= pix_err_cnt + 16'd1;
  end
`else
  logic unused_pix;
  assign unused_pix  = ^pixel_in;
  assign pix_err_cnt = '0;
`endif

endmodule

// File: doc/pattern_stream_checker.md
# pattern_stream_checker

- Receive end of the parallel pixel interface: consumes `pixel_in`/`line_valid`/`frame_valid` in the same clock domain as the grayscale ramp generator.
- Measures frame geometry and checks every pixel against the expected per-line ramp.
- Reports per-frame status plus running error and frame counts.
- Sits on the bring-up/self-test path, looped back directly from the generator output.

## Interface
- `EXP_WIDTH`, 240: expected active pixels per line.
- `EXP_HEIGHT`, 180: expected lines per frame.
- `PIXEL_W`, 10: pixel bit width.
- `CNT_W`, 12: width of geometry counters.
- `clk` in 1: single system clock (133 MHz).
- `reset` in 1: asynchronous, active-high reset.
- `pixel_in` in PIXEL_W: pixel data, valid while `line_valid`=1.
- `line_valid` in 1: active pixel qualifier.
- `frame_valid` in 1: frame envelope.
- `frame_done` out 1: one-cycle pulse, status outputs updated.
- `meas_width` out CNT_W: pixel count of first line of last frame.
- `meas_height` out CNT_W: line count of last frame.
- `geom_ok` out 1: last frame matched EXP_WIDTH on every line and EXP_HEIGHT lines.
- `frame_aborted` out 1: last frame ended with `line_valid` high.
- `stray_lv` out 1: sticky; `line_valid` seen while `frame_valid`=0.
- `pix_err_cnt` out 16: saturating count of mismatched pixels since reset.
- `frame_cnt` out 16: wrapping count of completed frames since reset.

## Operation
- States:
  - SYNC: after reset; wait for `frame_valid`=0, then go to IDLE. A frame in progress at reset release is ignored.
  - IDLE: on `frame_valid`=1 go to FRAME. Clear `x`, `y`, `line_bad` and first-line capture.
  - FRAME: count pixels in `x` while `line_valid`=1.
    - On `line_valid` falling: the first line captures `x` into the pending width; any line with `x`≠EXP_WIDTH sets `line_bad`. Then `y`++ and `x`←0.
    - On `frame_valid`=0: go to DONE.
  - DONE: one cycle. Pulse `frame_done`. Load `meas_width`, `meas_height`←`y`, `geom_ok`, `frame_aborted`, `frame_cnt`++. Go to IDLE.
- `geom_ok` = !`line_bad` && `y`==EXP_HEIGHT && !aborted.
- Abort: if `frame_valid` falls while `line_valid`=1, the partial line counts toward `y` but forces `geom_ok`=0 and `frame_aborted`=1.
- A line with zero pixels is impossible by construction, since lines are delimited by `line_valid`.
- Counters `x` and `y` saturate at 2^CNT_W−1; they never wrap.
- `stray_lv` is set in any state except SYNC; it is cleared only by reset.
- Pixel check (when compiled in): expected value = `x` mod 2^PIXEL_W. Each mismatch increments `pix_err_cnt`, saturating at 0xFFFF.

## Timing
- Inputs are sampled directly on `clk` with no synchronizers; the source is same-domain and registered.
- `line_valid` edges are detected against a 1-cycle registered copy.
- Pixel compare result is registered. `pix_err_cnt` updates 2 cycles after the offending pixel is sampled.
- `frame_done` asserts 2 cycles after the first cycle `frame_valid` is sampled low.
- All status outputs change only in the `frame_done` cycle and hold until the next one.
- A `frame_valid` low pulse of 1 cycle still completes a frame (DONE then IDLE).
- A `frame_valid` reassertion in the DONE cycle is caught in IDLE on the next cycle and is not lost: IDLE samples the level.
- Reset values: all outputs 0. FSM enters SYNC.
- Reset mid-frame discards the frame; no `frame_done` pulse.

## Configuration
- `PATTERN_CHECK_EN` defined: ramp comparator and `pix_err_cnt` logic are present.
- `PATTERN_CHECK_EN` undefined: no comparator is built. `pix_err_cnt` is tied to 0 and only geometry, abort and stray checks remain.

## Structure
- Shared package `pattern_pkg`:
  - FSM state enum (SYNC, IDLE, FRAME, DONE).
  - Default frame constants 240/180, shared with the generator.
  - Pixel width constant.
- One natural sub-module: `ramp_pixel_compare`. It holds the expected-value counter and the registered mismatch flag, and is instantiated only under `PATTERN_CHECK_EN`.

## Test plan
- Generator loopback, 3 full frames, EXP 240×180 → 3 `frame_done` pulses, `meas_width`=240, `meas_height`=180, `geom_ok`=1, `pix_err_cnt`=0, `frame_cnt`=3.
- Corrupt pixel x=17 (value 0x3FF) on line 5 → `pix_err_cnt`=1 after that frame, `geom_ok` still 1.
- Line 42 shortened to 239 pixels → `geom_ok`=0, `meas_width`=240, `frame_aborted`=0.
- `frame_valid` dropped mid-line on line 10 → `frame_done` pulse, `meas_height`=11, `geom_ok`=0, `frame_aborted`=1.
- Reset released mid-frame, then 1 clean frame → exactly 1 `frame_done`, `frame_cnt`=1, `geom_ok`=1.
- `line_valid` pulse with `frame_valid`=0 → `stray_lv`=1, held until `reset`; `frame_cnt` unchanged.
